// File: rtl/median_filter_pkg.sv
// Shared types for the median filter pipeline: pixel width, RGB word and the
// per-channel selector used by the output serializer.
`timescale 1ns/1ps
package median_filter_pkg;

    localparam int PIXEL_W      = 8;
    localparam int NUM_CHANNELS = 3;

    typedef enum logic [1:0] {
        CH_RED,
        CH_GREEN,
        CH_BLUE
    } channel_e;

    typedef struct packed {
        logic [PIXEL_W-1:0] red;
        logic [PIXEL_W-1:0] green;
        logic [PIXEL_W-1:0] blue;
    } rgb_word_t;

    function automatic logic [PIXEL_W-1:0] channel_sel(input rgb_word_t w, input channel_e c);
        case (c)
            CH_RED:   return w.red;
            CH_GREEN: return w.green;
            default:  return w.blue;
        endcase
    endfunction

endpackage

// File: rtl/pixel_valid_if.sv
// Filtered pixel stream: a valid strobe with one RGB word, no backpressure.
`timescale 1ns/1ps
interface pixel_valid_if;
    import median_filter_pkg::*;

    logic      valid;
    rgb_word_t pixel;

    modport master (output valid, output pixel);
    modport slave  (input valid, input pixel);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage; a write into a full FIFO is accepted
// when a read happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              wr_ok, rd_ok;

    always_comb begin
        full    = (level_q == (AW+1)'(DEPTH));
        empty   = (level_q == '0);
        rd_ok   = rd_en && !empty;
        wr_ok   = wr_en && (!full || rd_ok);
        mem_d   = mem_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = wr_ptr_q + (wr_ok ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (rd_ok ? AW'(1) : AW'(0));
        level_d  = level_q + (wr_ok ? (AW+1)'(1) : (AW+1)'(0))
                           - (rd_ok ? (AW+1)'(1) : (AW+1)'(0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/pixel_serializer.sv
// Buffers filtered pixels and emits them one colour channel per beat.
// Build option: PIXEL_SERIALIZER_FRAME_LAST_EN enables m_last_o / frame_done_o.
`timescale 1ns/1ps
module pixel_serializer
    import median_filter_pkg::*;
#(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pixel_valid_if.slave                  pixel_valid_if_i,
    output logic [PIXEL_W-1:0]            m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          frame_done_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Output handshake: a beat moves when m_valid_o && m_ready_i on a rising
    // edge; once raised, m_valid_o and the beat contents hold until that happens.
    rgb_word_t hold_q, hold_d;
    logic      hold_valid_q, hold_valid_d;
    channel_e  ch_q, ch_d;
    logic      overflow_q, overflow_d;

    logic      xfer, blue_xfer, hold_free, bypass, drop;
    logic      fifo_wr, fifo_rd, fifo_full, fifo_empty;
    rgb_word_t fifo_rd_data;
    logic [LW-1:0] fifo_level;

    sync_fifo #(
        .DATA_W ($bits(rgb_word_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (pixel_valid_if_i.pixel),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The holding register is refilled on the edge its last beat leaves; an
    // incoming pixel skips the empty FIFO so the first beat appears next cycle.
    always_comb begin
        xfer         = hold_valid_q && m_ready_i;
        blue_xfer    = xfer && (ch_q == CH_BLUE);
        hold_free    = !hold_valid_q || blue_xfer;
        fifo_rd      = hold_free && !fifo_empty;
        bypass       = hold_free && fifo_empty && pixel_valid_if_i.valid;
        fifo_wr      = pixel_valid_if_i.valid && !bypass && (!fifo_full || fifo_rd);
        drop         = pixel_valid_if_i.valid && !bypass && fifo_full && !fifo_rd;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (hold_free) begin
            if (!fifo_empty) begin
                hold_d       = fifo_rd_data;
                hold_valid_d = 1'b1;
            end else if (pixel_valid_if_i.valid) begin
                hold_d       = pixel_valid_if_i.pixel;
                hold_valid_d = 1'b1;
            end else begin
                hold_valid_d = 1'b0;
            end
        end
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Channel FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q <= CH_RED;
        end else begin
            ch_q <= ch_d;
        end
    end

    // Channel FSM: next state, advancing only on a transfer.
    always_comb begin
        ch_d = ch_q;
        if (xfer) begin
            case (ch_q)
                CH_RED:   ch_d = CH_GREEN;
                CH_GREEN: ch_d = CH_BLUE;
                default:  ch_d = CH_RED;
            endcase
        end
    end

    // Channel FSM: outputs.
    always_comb begin
        m_valid_o = hold_valid_q;
        m_data_o  = channel_sel(hold_q, ch_q);
    end

`ifdef PIXEL_SERIALIZER_FRAME_LAST_EN
    localparam int FRAME_PIX = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             at_last;

    always_comb begin
        at_last      = (pix_cnt_q == CNT_W'(FRAME_PIX - 1));
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = blue_xfer && at_last;
        if (blue_xfer) begin
            pix_cnt_d = at_last ? '0 : pix_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_last_o     = hold_valid_q && (ch_q == CH_BLUE) && at_last;
    assign frame_done_o = frame_done_q;
`else
    assign m_last_o     = 1'b0;
    assign frame_done_o = 1'b0;
`endif

    assign overflow_o   = overflow_q;
    assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer: vector table for basic streaming and
// stalls, then hand sequences for overflow, full push/pop, frame end and reset.
`timescale 1ns/1ps
module tb_pixel_serializer;
  import median_filter_pkg::*;

  localparam int IL          = 4;
  localparam int IH          = 3;
  localparam int DEPTH       = 16;
  localparam int LW          = $clog2(DEPTH) + 1;
  localparam int FRAME_BEATS = 3 * (IL - 1) * (IH - 1);
`ifdef PIXEL_SERIALIZER_FRAME_LAST_EN
  localparam bit LAST_EN    = 1'b1;
  localparam int EXP_FRAMES = 2;
`else
  localparam bit LAST_EN    = 1'b0;
  localparam int EXP_FRAMES = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PIXEL_W-1:0] m_data_o;
  logic               m_valid_o;
  logic               m_ready_i;
  logic               m_last_o;
  logic               frame_done_o;
  logic               overflow_o;
  logic [LW-1:0]      fifo_level_o;

  pixel_valid_if pv();

  pixel_serializer #(
    .IMAGE_LEN    (IL),
    .IMAGE_HEIGHT (IH),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_valid_if_i (pv),
    .m_data_o         (m_data_o),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .m_last_o         (m_last_o),
    .frame_done_o     (frame_done_o),
    .overflow_o       (overflow_o),
    .fifo_level_o     (fifo_level_o)
  );

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         beat_cnt;
  logic       chk_last;
  logic       prev_stall;
  logic [7:0] prev_data;
  int         last_seen;
  int         fd_seen;

  typedef struct {
    logic        in_v;
    logic [23:0] pix;
    logic        rdy;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [4:0]  exp_lvl;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mkpx(input int i);
    logic [7:0] b;
    b = 8'(i * 7 + 3);
    return {b, b + 8'd1, b + 8'd2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with scoreboard tracking of the beat that leaves on this edge.
  task automatic step_chk();
    logic xf;
    logic el;
    xf = m_valid_o && m_ready_i;
    el = LAST_EN && (beat_cnt == FRAME_BEATS - 1);
    if (m_valid_o) begin
      if (prev_stall) check("stall_data", 32'(m_data_o), 32'(prev_data));
      if (chk_last) check("m_last", 32'(m_last_o), 32'(el));
    end
    if (xf) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none at %0t", m_data_o, $time);
      end else begin
        check("beat_data", 32'(m_data_o), 32'(exp_q.pop_front()));
      end
      if (m_last_o) last_seen++;
      beat_cnt = (beat_cnt + 1) % FRAME_BEATS;
    end
    prev_stall = m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    step();
    if (chk_last) check("frame_done", 32'(frame_done_o), 32'(xf && el));
    if (frame_done_o) fd_seen++;
  endtask

  task automatic push_px(input logic [23:0] px, input logic sb);
    pv.valid = 1'b1;
    pv.pixel = px;
    if (sb) begin
      exp_q.push_back(px[23:16]);
      exp_q.push_back(px[15:8]);
      exp_q.push_back(px[7:0]);
    end
    step_chk();
    pv.valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < budget) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      step_chk();
      n++;
    end
    m_ready_i = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(m_valid_o), 32'd0);
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    pv.valid  = 1'b0;
    pv.pixel  = '0;
    m_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    exp_q.delete();
    beat_cnt   = 0;
    prev_stall = 1'b0;
    last_seen  = 0;
    fd_seen    = 0;
  endtask

  initial begin
    logic [23:0] px;

    vecs[0]  = '{1'b1, 24'h112233, 1'b1, 1'b1, 8'h11, 5'd0};
    vecs[1]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h22, 5'd0};
    vecs[2]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h33, 5'd0};
    vecs[3]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[4]  = '{1'b1, 24'h445566, 1'b1, 1'b1, 8'h44, 5'd0};
    vecs[5]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h55, 5'd0};
    vecs[6]  = '{1'b1, 24'h778899, 1'b0, 1'b1, 8'h55, 5'd1};
    vecs[7]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h55, 5'd1};
    vecs[8]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h55, 5'd1};
    vecs[9]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h55, 5'd1};
    vecs[10] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h55, 5'd1};
    vecs[11] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h66, 5'd1};
    vecs[12] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h77, 5'd0};
    vecs[13] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h88, 5'd0};
    vecs[14] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h99, 5'd0};
    vecs[15] = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 5'd0};

    pv.valid   = 1'b0;
    pv.pixel   = '0;
    m_ready_i  = 1'b0;
    chk_last   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    beat_cnt   = 0;
    last_seen  = 0;
    fd_seen    = 0;

    // reset values while reset is held
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_data", 32'(m_data_o), 32'd0);
    check("rst_last", 32'(m_last_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // single pixel and backpressure on the green beat
    for (int i = 0; i < 16; i++) begin
      pv.valid  = vecs[i].in_v;
      pv.pixel  = vecs[i].pix;
      m_ready_i = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i), 32'(m_valid_o), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) check($sformatf("vec%0d_data", i), 32'(m_data_o), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_level", i), 32'(fifo_level_o), 32'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_last", i), 32'(m_last_o), 32'd0);
      check($sformatf("vec%0d_done", i), 32'(frame_done_o), 32'd0);
      check($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'd0);
    end
    pv.valid = 1'b0;

    // frame end: two 6-pixel frames
    apply_reset();
    chk_last = 1'b1;
    for (int k = 0; k < 12; k++) push_px(mkpx(k), 1'b1);
    check("frame_level", 32'(fifo_level_o), 32'd11);
    drain(400);
    check("frame_last_count", 32'(last_seen), 32'(EXP_FRAMES));
    check("frame_done_count", 32'(fd_seen), 32'(EXP_FRAMES));

    // overflow: 18 pushes while stalled, 17 kept
    apply_reset();
    chk_last = 1'b0;
    for (int k = 0; k < 18; k++) begin
      push_px(mkpx(k + 20), (k < 17));
      if (k == 16) begin
        check("ovf_level17", 32'(fifo_level_o), 32'd16);
        check("ovf_before", 32'(overflow_o), 32'd0);
      end
    end
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_level18", 32'(fifo_level_o), 32'd16);
    drain(400);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // full FIFO: push on the same edge as the blue transfer
    apply_reset();
    chk_last = 1'b0;
    for (int k = 0; k < 17; k++) push_px(mkpx(k + 40), 1'b1);
    check("full_level", 32'(fifo_level_o), 32'd16);
    m_ready_i = 1'b1;
    step_chk();
    step_chk();
    check("full_blue_pending", 32'(m_data_o), 32'(exp_q[0]));
    push_px(mkpx(99), 1'b1);
    check("full_pp_level", 32'(fifo_level_o), 32'd16);
    check("full_pp_ovf", 32'(overflow_o), 32'd0);
    check("full_pp_next", 32'(m_data_o), 32'(exp_q[0]));
    drain(400);
    check("full_ovf_end", 32'(overflow_o), 32'd0);

    // reset with five pixels buffered
    apply_reset();
    chk_last = 1'b1;
    for (int k = 0; k < 6; k++) push_px(mkpx(k + 60), 1'b1);
    check("mrst_level_before", 32'(fifo_level_o), 32'd5);
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(m_valid_o), 32'd0);
    check("mrst_level", 32'(fifo_level_o), 32'd0);
    check("mrst_data", 32'(m_data_o), 32'd0);
    check("mrst_last", 32'(m_last_o), 32'd0);
    exp_q.delete();
    beat_cnt   = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    px = mkpx(77);
    push_px(px, 1'b1);
    check("mrst_new_valid", 32'(m_valid_o), 32'd1);
    check("mrst_new_data", 32'(m_data_o), 32'(px[23:16]));
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
